// File: rtl/asrv32_regfile.sv
// ASRV32 base register file (RV32I/RV32E), 1-cycle registered reads gated by i_ce_rd, no backpressure;
// post-reset clear sequencer drives o_ready. Define ASRV32_REGFILE_BYPASS_EN for write-first forwarding.
module asrv32_regfile #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_ce_rd,
  input  logic            i_ce_wr,
  input  logic [4:0]      i_rs1_addr,
  input  logic [4:0]      i_rs2_addr,
  input  logic [4:0]      i_rd_addr,
  input  logic [XLEN-1:0] i_rd_data,
  output logic [XLEN-1:0] o_rs1_data,
  output logic [XLEN-1:0] o_rs2_data,
  output logic            o_rs_illegal,
  output logic            o_ready
);

  localparam int         AW      = $clog2(NREGS);
  localparam logic [5:0] NREGS_W = 6'(NREGS);
  localparam logic [4:0] LAST    = 5'(NREGS - 1);

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t          state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic [XLEN-1:0] rs1_q, rs1_d, rs2_q, rs2_d;
  logic            illegal_q, illegal_d;
  logic            ready_q, ready_d;
  logic            wr_en;

  function automatic logic is_legal(input logic [4:0] a);
    return ({1'b0, a} < NREGS_W);
  endfunction

  assign wr_en = (state_q == ST_READY) && i_ce_wr && (i_rd_addr != 5'd0) && is_legal(i_rd_addr);

  // x0 and out-of-range addresses read as zero
  function automatic logic [XLEN-1:0] rd_val(input logic [4:0] a);
    logic [XLEN-1:0] v;
    v = '0;
    if ((a != 5'd0) && is_legal(a)) begin
      v = regs_q[a[AW-1:0]];
`ifdef ASRV32_REGFILE_BYPASS_EN
      if (wr_en && (a == i_rd_addr)) v = i_rd_data;
`endif
    end
    return v;
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    regs_d    = regs_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    illegal_d = illegal_q;
    ready_d   = ready_q;
    case (state_q)
      ST_CLEAR: begin
        regs_d[cnt_q[AW-1:0]] = '0;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == LAST) begin
          state_d = ST_READY;
          ready_d = 1'b1;
        end
      end
      default: begin
        if (wr_en) regs_d[i_rd_addr[AW-1:0]] = i_rd_data;
        if (i_ce_rd) begin
          rs1_d     = rd_val(i_rs1_addr);
          rs2_d     = rd_val(i_rs2_addr);
          illegal_d = !is_legal(i_rs1_addr) || !is_legal(i_rs2_addr);
        end
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_CLEAR;
      cnt_q     <= 5'd1;
      rs1_q     <= '0;
      rs2_q     <= '0;
      illegal_q <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      illegal_q <= illegal_d;
      ready_q   <= ready_d;
    end
  end

  // array has no reset; the clear sequencer zeroes it, and no write lands on a reset edge
  always_ff @(posedge i_clk) begin
    if (!i_rst) regs_q <= regs_d;
  end

  assign o_rs1_data   = rs1_q;
  assign o_rs2_data   = rs2_q;
  assign o_rs_illegal = illegal_q;
  assign o_ready      = ready_q;

endmodule

// File: tb/tb_asrv32_regfile.sv
// Bench for asrv32_regfile: RV32I and RV32E instances on shared stimulus, checked every cycle
// against an array model, plus literal expectations from the directed scenarios.
module tb_asrv32_regfile;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce_rd = 1'b0;
  logic        ce_wr = 1'b0;
  logic [4:0]  rs1 = 5'd0;
  logic [4:0]  rs2 = 5'd0;
  logic [4:0]  rd = 5'd0;
  logic [31:0] wd = 32'd0;

  logic [31:0] d_r1 [2];
  logic [31:0] d_r2 [2];
  logic        d_ill [2];
  logic        d_rdy [2];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  asrv32_regfile #(.XLEN(32), .NREGS(32)) u32 (
    .i_clk(clk), .i_rst(rst), .i_ce_rd(ce_rd), .i_ce_wr(ce_wr),
    .i_rs1_addr(rs1), .i_rs2_addr(rs2), .i_rd_addr(rd), .i_rd_data(wd),
    .o_rs1_data(d_r1[0]), .o_rs2_data(d_r2[0]), .o_rs_illegal(d_ill[0]), .o_ready(d_rdy[0])
  );

  asrv32_regfile #(.XLEN(32), .NREGS(16)) u16 (
    .i_clk(clk), .i_rst(rst), .i_ce_rd(ce_rd), .i_ce_wr(ce_wr),
    .i_rs1_addr(rs1), .i_rs2_addr(rs2), .i_rd_addr(rd), .i_rd_data(wd),
    .o_rs1_data(d_r1[1]), .o_rs2_data(d_r2[1]), .o_rs_illegal(d_ill[1]), .o_ready(d_rdy[1])
  );

  // Model: index 0 is the 32-register instance, index 1 the 16-register one
  logic [31:0] m_mem [2][32];
  int          m_clr [2];
  bit          m_rdy [2];
  logic [31:0] m_r1 [2];
  logic [31:0] m_r2 [2];
  bit          m_ill [2];
  bit          started = 1'b0;

  function automatic logic [31:0] m_read(input int k, input int n, input int a);
    if (a == 0 || a >= n) return 32'd0;
`ifdef ASRV32_REGFILE_BYPASS_EN
    if (ce_wr && a == int'(rd)) return wd;
`endif
    return m_mem[k][a];
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int n;
      n = (k == 0) ? 32 : 16;
      if (rst) begin
        started = 1'b1;
        m_clr[k] = 0; m_rdy[k] = 1'b0;
        m_r1[k] = 32'd0; m_r2[k] = 32'd0; m_ill[k] = 1'b0;
      end else if (!m_rdy[k]) begin
        m_clr[k] = m_clr[k] + 1;
        if (m_clr[k] == n - 1) begin
          m_rdy[k] = 1'b1;
          for (int i = 0; i < 32; i++) m_mem[k][i] = 32'd0;
        end
      end else begin
        if (ce_rd) begin
          m_r1[k]  = m_read(k, n, int'(rs1));
          m_r2[k]  = m_read(k, n, int'(rs2));
          m_ill[k] = (int'(rs1) >= n) || (int'(rs2) >= n);
        end
        if (ce_wr && rd != 5'd0 && int'(rd) < n) m_mem[k][rd] = wd;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 2; k++) begin
        check((k == 0) ? "m32_rs1" : "m16_rs1", d_r1[k], m_r1[k]);
        check((k == 0) ? "m32_rs2" : "m16_rs2", d_r2[k], m_r2[k]);
        check((k == 0) ? "m32_ill" : "m16_ill", {31'd0, d_ill[k]}, {31'd0, m_ill[k]});
        check((k == 0) ? "m32_rdy" : "m16_rdy", {31'd0, d_rdy[k]}, {31'd0, m_rdy[k]});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] v);
    ce_rd = 1'b0; ce_wr = 1'b1; rd = a; wd = v;
    tick();
    ce_wr = 1'b0;
  endtask

  task automatic rdp(input logic [4:0] a1, input logic [4:0] a2);
    ce_wr = 1'b0; ce_rd = 1'b1; rs1 = a1; rs2 = a2;
    tick();
    ce_rd = 1'b0;
  endtask

  initial begin
    // Clear sequence
    tick(); tick();
    rst = 1'b0;
    check("rdy_after_rst", {31'd0, d_rdy[0]}, 32'd0);
    for (int e = 1; e <= 30; e++) tick();
    check("rdy_edge30", {31'd0, d_rdy[0]}, 32'd0);
    tick();
    check("rdy_edge31", {31'd0, d_rdy[0]}, 32'd1);
    check("rdy16_done", {31'd0, d_rdy[1]}, 32'd1);
    for (int a = 1; a < 32; a++) begin
      rdp(5'(a), 5'(31 - a));
      check("clear_zero", d_r1[0], 32'd0);
    end

    // Basic access
    wr(5'd5, 32'hDEADBEEF);
    wr(5'd31, 32'h12345678);
    rdp(5'd5, 5'd31);
    check("x5", d_r1[0], 32'hDEADBEEF);
    check("x31", d_r2[0], 32'h12345678);
    check("e_x31_ill", {31'd0, d_ill[1]}, 32'd1);
    check("e_x31_zero", d_r2[1], 32'd0);
    ce_wr = 1'b1; rd = 5'd0; wd = 32'hFFFFFFFF; ce_rd = 1'b1; rs1 = 5'd0; rs2 = 5'd0;
    tick();
    check("x0_same_edge", d_r1[0], 32'd0);
    rdp(5'd0, 5'd5);
    check("x0_after", d_r1[0], 32'd0);

    // Forwarding
    wr(5'd7, 32'h11111111);
    ce_wr = 1'b1; rd = 5'd7; wd = 32'h22222222; ce_rd = 1'b1; rs1 = 5'd7; rs2 = 5'd7;
    tick();
`ifdef ASRV32_REGFILE_BYPASS_EN
    check("fwd_same_edge", d_r1[0], 32'h22222222);
`else
    check("fwd_same_edge", d_r1[0], 32'h11111111);
`endif
    rdp(5'd7, 5'd7);
    check("fwd_next", d_r1[0], 32'h22222222);

    // Hold
    wr(5'd3, 32'hA5A5A5A5);
    rdp(5'd3, 5'd3);
    check("hold_cap", d_r1[0], 32'hA5A5A5A5);
    wr(5'd3, 32'h5A5A5A5A);
    tick();
    check("hold_keep", d_r1[0], 32'hA5A5A5A5);
    rdp(5'd3, 5'd0);
    check("hold_reread", d_r1[0], 32'h5A5A5A5A);

    // RV32E illegal access
    wr(5'd20, 32'hCAFEF00D);
    rdp(5'd20, 5'd0);
    check("e_x20_data", d_r1[1], 32'd0);
    check("e_x20_ill", {31'd0, d_ill[1]}, 32'd1);
    check("i_x20_data", d_r1[0], 32'hCAFEF00D);
    rdp(5'd2, 5'd3);
    check("e_ill_clr", {31'd0, d_ill[1]}, 32'd0);
    check("e_x3", d_r2[1], 32'h5A5A5A5A);

    // Reset from READY, then again mid-clear
    wr(5'd5, 32'h1);
    rst = 1'b1; tick(); rst = 1'b0;
    for (int e = 1; e <= 9; e++) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    for (int e = 1; e <= 30; e++) tick();
    check("rst2_edge30", {31'd0, d_rdy[0]}, 32'd0);
    tick();
    check("rst2_edge31", {31'd0, d_rdy[0]}, 32'd1);
    rdp(5'd5, 5'd3);
    check("x5_cleared", d_r1[0], 32'd0);
    check("x3_cleared", d_r2[0], 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
